// File: rtl/gpu_pkg.sv
// Shared definitions for the core front end.
//   - Program memory address/data widths.
//   - Scheduler (core_state) encodings that the fetch stage reacts to.
//   - Fetcher FSM state encoding, which is also driven out as fetcher_state.
package gpu_pkg;

    localparam int PROGRAM_MEM_ADDR_W = 8;
    localparam int PROGRAM_MEM_DATA_W = 16;

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

endpackage

// File: rtl/instr_fetcher_if.sv
// Program-memory read port between the instruction fetcher and program memory.
//   mem_read_valid    request pending (driven by the fetcher)
//   mem_read_address  request address (driven by the fetcher)
//   mem_read_ready    memory returns data this cycle (driven by memory)
//   mem_read_data     returned instruction word (driven by memory)
// Modports: master = fetcher side, slave = memory side.
interface instr_fetcher_if
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = PROGRAM_MEM_ADDR_W,
    parameter int DATA_BITS = PROGRAM_MEM_DATA_W
);

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );

endinterface

// File: rtl/ibuf_dm.sv
// Direct-mapped instruction buffer, one instruction word per line.
//   clk, reset        core clock, asynchronous active-high reset (clears valid bits)
//   clear_all         synchronous invalidate of every line; wins over a same-cycle write
//   lookup_addr       address to look up (combinational)
//   lookup_hit        line at the address index is valid and its tag matches
//   lookup_data       data stored in the indexed line
//   wr_en/wr_addr/wr_data  single write port, fills the line indexed by wr_addr
module ibuf_dm #(
    parameter int BUF_ENTRIES = 4,
    parameter int ADDR_BITS   = 8,
    parameter int DATA_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_all,
    input  logic [ADDR_BITS-1:0] lookup_addr,
    output logic                 lookup_hit,
    output logic [DATA_BITS-1:0] lookup_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data
);

    localparam int IDX_BITS = $clog2(BUF_ENTRIES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [BUF_ENTRIES-1:0] line_valid;
    logic [TAG_BITS-1:0]    line_tag  [BUF_ENTRIES];
    logic [DATA_BITS-1:0]   line_data [BUF_ENTRIES];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0] wr_tag;

    assign lk_idx = lookup_addr[IDX_BITS-1:0];
    assign lk_tag = lookup_addr[ADDR_BITS-1:IDX_BITS];
    assign wr_idx = wr_addr[IDX_BITS-1:0];
    assign wr_tag = wr_addr[ADDR_BITS-1:IDX_BITS];

    assign lookup_hit  = line_valid[lk_idx] && (line_tag[lk_idx] == lk_tag);
    assign lookup_data = line_data[lk_idx];

    // Valid bits are the only state that needs resetting; tag/data are
    // meaningless until their valid bit is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_valid <= '0;
        end else if (clear_all) begin
            line_valid <= '0;
        end else if (wr_en) begin
            line_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear_all) begin
            line_tag[wr_idx]  <= wr_tag;
            line_data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetch stage, directly upstream of the decoder.
//   clk, reset     core clock, asynchronous active-high reset
//   core_state     scheduler state (CORE_FETCH starts a fetch, CORE_DECODE releases it)
//   current_pc     PC of the next instruction; sampled only when a fetch starts
//   flush          invalidate every buffer line
//   mem            program-memory read port (valid/ready handshake)
//   fetcher_state  FETCHER_IDLE / FETCHER_FETCHING / FETCHER_FETCHED
//   instruction    fetched word, held until the next fill or buffer hit
// Buffer hits complete in one cycle with no memory request; misses go to
// program memory and fill the buffer line on return.
module instr_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_W,
    parameter int PROGRAM_MEM_DATA_BITS = PROGRAM_MEM_DATA_W,
    parameter int BUF_ENTRIES           = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    instr_fetcher_if.master                  mem,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    fetcher_state_t                   state;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q;
    logic                             flush_seen;
    logic                             lookup_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] lookup_data;
    logic                             fill_we;
    logic                             start_fetch;

    assign start_fetch = (state == FETCHER_IDLE) && (core_state == CORE_FETCH);

    // A flush anywhere in the miss window (including the return cycle) means
    // the returning word may belong to a stale program image: deliver it, but
    // do not cache it.
    assign fill_we = (state == FETCHER_FETCHING) && mem.mem_read_valid &&
                     mem.mem_read_ready && !flush && !flush_seen;

    ibuf_dm #(
        .BUF_ENTRIES (BUF_ENTRIES),
        .ADDR_BITS   (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS   (PROGRAM_MEM_DATA_BITS)
    ) u_ibuf (
        .clk         (clk),
        .reset       (reset),
        .clear_all   (flush),
        .lookup_addr (current_pc),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .wr_en       (fill_we),
        .wr_addr     (pc_q),
        .wr_data     (mem.mem_read_data)
    );

    // pc_q is only consumed while FETCHING, after it has been loaded.
    always_ff @(posedge clk) begin
        if (start_fetch) begin
            pc_q <= current_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= FETCHER_IDLE;
            mem.mem_read_valid   <= 1'b0;
            mem.mem_read_address <= '0;
            instruction          <= '0;
            flush_seen           <= 1'b0;
        end else begin
            case (state)
                FETCHER_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        if (lookup_hit && !flush) begin
                            instruction <= lookup_data;
                            state       <= FETCHER_FETCHED;
                        end else begin
                            mem.mem_read_valid   <= 1'b1;
                            mem.mem_read_address <= current_pc;
                            flush_seen           <= 1'b0;
                            state                <= FETCHER_FETCHING;
                        end
                    end
                end
                FETCHER_FETCHING: begin
                    if (flush) begin
                        flush_seen <= 1'b1;
                    end
                    if (mem.mem_read_ready) begin
                        instruction        <= mem.mem_read_data;
                        mem.mem_read_valid <= 1'b0;
                        state              <= FETCHER_FETCHED;
                    end
                end
                FETCHER_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state <= FETCHER_IDLE;
                    end
                end
                default: state <= FETCHER_IDLE;
            endcase
        end
    end

    assign fetcher_state = state;

endmodule

// File: tb/tb_instr_fetcher.sv
module tb_instr_fetcher;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        flush;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    instr_fetcher_if mem_if ();

    instr_fetcher #(.BUF_ENTRIES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .flush         (flush),
        .mem           (mem_if.master),
        .fetcher_state (fetcher_state),
        .instruction   (instruction)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // Program image and a line-level model of the buffer: which full PC each
    // of the 4 lines currently holds.
    logic [15:0] mem_image [256];
    bit          mv  [4];
    logic [7:0]  mpc [4];

    typedef struct {
        logic [7:0] pc;
        int         lat;
        bit         fl_lookup;
        bit         fl_mid;
        bit         pc_chg;
        bit         exp_hit;
    } vec_t;

    vec_t tab [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    endtask

    function automatic bit model_hit(input logic [7:0] pc);
        return mv[pc[1:0]] && (mpc[pc[1:0]] == pc);
    endfunction

    // One complete fetch/decode round trip, starting and ending at a negedge
    // with the fetcher in IDLE.
    task automatic fetch_txn(input logic [7:0] pc, input int lat, input bit fl_lookup,
                             input bit fl_mid, input bit pc_chg, input logic [7:0] alt,
                             input bit exp_hit);
        logic [15:0] d;
        d = mem_image[pc];
        core_state = CORE_FETCH;
        current_pc = pc;
        flush      = fl_lookup;
        @(negedge clk);
        core_state = 3'b000;
        flush      = 1'b0;
        if (fl_lookup) model_clear();
        if (exp_hit) begin
            chk("hit_state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
            chk("hit_req_valid", 32'(mem_if.mem_read_valid), 32'd0);
            chk("hit_instr", 32'(instruction), 32'(d));
        end else begin
            for (int k = 0; k < lat; k++) begin
                chk("miss_state", 32'(fetcher_state), 32'(FETCHER_FETCHING));
                chk("req_valid", 32'(mem_if.mem_read_valid), 32'd1);
                chk("req_addr", 32'(mem_if.mem_read_address), 32'(pc));
                flush = fl_mid && (k == 0);
                if (pc_chg) current_pc = alt;
                if (k == lat - 1) begin
                    mem_if.mem_read_ready = 1'b1;
                    mem_if.mem_read_data  = d;
                end else begin
                    mem_if.mem_read_ready = 1'b0;
                    mem_if.mem_read_data  = 16'($urandom);
                end
                @(negedge clk);
            end
            mem_if.mem_read_ready = 1'b0;
            flush      = 1'b0;
            current_pc = pc;
            chk("fill_req_valid", 32'(mem_if.mem_read_valid), 32'd0);
            chk("fill_state", 32'(fetcher_state), 32'(FETCHER_FETCHED));
            chk("fill_instr", 32'(instruction), 32'(d));
            if (fl_mid) begin
                model_clear();
            end else begin
                mv[pc[1:0]]  = 1'b1;
                mpc[pc[1:0]] = pc;
            end
        end
        core_state = CORE_DECODE;
        @(negedge clk);
        core_state = 3'b000;
        chk("decode_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        chk("held_instr", 32'(instruction), 32'(d));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_image[i] = 16'($urandom);
        mem_image[8'h05] = 16'h9A07;
        model_clear();

        //              pc    lat fl_lk fl_mid pc_chg hit
        tab[0]  = '{8'h05, 3, 1'b0, 1'b0, 1'b0, 1'b0}; // cold miss
        tab[1]  = '{8'h05, 1, 1'b0, 1'b0, 1'b0, 1'b1}; // hit
        tab[2]  = '{8'h01, 2, 1'b0, 1'b0, 1'b0, 1'b0}; // evicts 05
        tab[3]  = '{8'h05, 1, 1'b0, 1'b0, 1'b0, 1'b0}; // evicts 01
        tab[4]  = '{8'h01, 2, 1'b0, 1'b0, 1'b0, 1'b0}; // conflict miss
        tab[5]  = '{8'h02, 2, 1'b0, 1'b1, 1'b0, 1'b0}; // flush while fetching
        tab[6]  = '{8'h02, 3, 1'b0, 1'b0, 1'b1, 1'b0}; // misses again, pc moves
        tab[7]  = '{8'h02, 1, 1'b0, 1'b0, 1'b0, 1'b1}; // line filled for 02
        tab[8]  = '{8'h40, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[9]  = '{8'h02, 1, 1'b1, 1'b0, 1'b0, 1'b0}; // flush at lookup wins
        tab[10] = '{8'h02, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[11] = '{8'h40, 1, 1'b0, 1'b0, 1'b0, 1'b0}; // cleared by that flush
        tab[12] = '{8'h40, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[13] = '{8'h05, 1, 1'b0, 1'b1, 1'b0, 1'b0}; // flush on return cycle
        tab[14] = '{8'h05, 2, 1'b0, 1'b0, 1'b0, 1'b0}; // not cached
        tab[15] = '{8'h05, 1, 1'b0, 1'b0, 1'b0, 1'b1};

        reset                 = 1'b1;
        core_state            = 3'b000;
        current_pc            = 8'h00;
        flush                 = 1'b0;
        mem_if.mem_read_ready = 1'b0;
        mem_if.mem_read_data  = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        chk("rst_req_valid", 32'(mem_if.mem_read_valid), 32'd0);
        chk("rst_req_addr", 32'(mem_if.mem_read_address), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            fetch_txn(tab[i].pc, tab[i].lat, tab[i].fl_lookup, tab[i].fl_mid,
                      tab[i].pc_chg, 8'h40, tab[i].exp_hit);
        end

        // Ready with no request pending and a non-FETCH/DECODE core_state
        // must leave everything untouched.
        core_state            = 3'b100;
        mem_if.mem_read_ready = 1'b1;
        mem_if.mem_read_data  = 16'hDEAD;
        @(negedge clk);
        chk("stray_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        chk("stray_req_valid", 32'(mem_if.mem_read_valid), 32'd0);
        chk("stray_instr", 32'(instruction), 32'(mem_image[8'h05]));
        core_state            = 3'b000;
        mem_if.mem_read_ready = 1'b0;

        // Asynchronous reset in the middle of a miss.
        core_state = CORE_FETCH;
        current_pc = 8'h13;
        @(negedge clk);
        core_state = 3'b000;
        chk("pre_rst_state", 32'(fetcher_state), 32'(FETCHER_FETCHING));
        @(negedge clk);
        reset                 = 1'b1;
        mem_if.mem_read_ready = 1'b1;
        mem_if.mem_read_data  = 16'hBEEF;
        #1;
        chk("async_rst_req_valid", 32'(mem_if.mem_read_valid), 32'd0);
        chk("async_rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        chk("async_rst_instr", 32'(instruction), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_state", 32'(fetcher_state), 32'(FETCHER_IDLE));
        chk("post_rst_instr", 32'(instruction), 32'd0);
        mem_if.mem_read_ready = 1'b0;
        model_clear();
        fetch_txn(8'h05, 2, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0);

        // Random traffic over 16 PCs (4 tags per line) against the line model.
        for (int n = 0; n < 120; n++) begin
            logic [7:0] pc;
            logic [7:0] alt;
            bit         fl_lk;
            bit         fl_md;
            bit         chg;
            int         lat;
            pc    = 8'($urandom_range(0, 3) << 4) | 8'($urandom_range(0, 3));
            alt   = 8'($urandom);
            lat   = $urandom_range(1, 4);
            fl_lk = ($urandom_range(0, 7) == 0);
            fl_md = ($urandom_range(0, 5) == 0);
            chg   = ($urandom_range(0, 3) == 0);
            fetch_txn(pc, lat, fl_lk, fl_md, chg, alt, !fl_lk && model_hit(pc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
